id_stall_controller: RTL

//  Pipeline sequencer for ID-stage operand forwarding. It detects operands that cannot be forwarded into ID in time:
//  - loads still in EX or MEM;
//  - branch-in-ID operands produced in EX.
//  It stalls PC/IF_ID, injects bubbles into ID_EX, freezes the pipe on data-memory wait and flushes IF_ID on a taken branch.
//  It sits beside the ID-stage forwarding mux and owns every pipeline-register write enable.

---
 rtl/id_stall_controller_pkg.sv | 22 ++
 rtl/id_stall_controller_if.sv | 35 +++
 rtl/id_stall_controller_hazard_detect.sv | 47 ++++
 rtl/id_stall_controller.sv | 125 ++++++++++++
 4 files changed

// File: rtl/id_stall_controller_pkg.sv
// rtl/id_stall_controller_pkg.sv - shared pipeline types and constants for the ID stall controller
package id_stall_controller_pkg;

    localparam logic [1:0] ST_RUN_ENC  = 2'd0;
    localparam logic [1:0] ST_HAZ_ENC  = 2'd1;
    localparam logic [1:0] ST_WAIT_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN  = ST_RUN_ENC,
        ST_HAZ  = ST_HAZ_ENC,
        ST_WAIT = ST_WAIT_ENC
    } state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    // x0 is hardwired to zero, so a write to it never creates a dependency
    function automatic logic reg_match(input logic [4:0] rd, input logic regwrite,
                                       input logic [4:0] rs, input logic use_rs);
        return regwrite && use_rs && (rd != REG_X0) && (rd == rs);
    endfunction

endpackage

// File: rtl/id_stall_controller_if.sv
// rtl/id_stall_controller_if.sv - pipeline hazard inputs and pipeline-register control outputs
interface id_stall_controller_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       id_is_branch;
    logic       branch_taken;
    logic [4:0] id_ex_rd;
    logic       id_ex_regwrite;
    logic       id_ex_memread;
    logic [4:0] ex_mem_rd;
    logic       ex_mem_regwrite;
    logic       ex_mem_memread;
    logic       dmem_busy;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_bubble;
    logic       pipe_freeze;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_branch, branch_taken,
        output id_ex_rd, id_ex_regwrite, id_ex_memread,
        output ex_mem_rd, ex_mem_regwrite, ex_mem_memread, dmem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_branch, branch_taken,
        input  id_ex_rd, id_ex_regwrite, id_ex_memread,
        input  ex_mem_rd, ex_mem_regwrite, ex_mem_memread, dmem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze
    );
endinterface

// File: rtl/id_stall_controller_hazard_detect.sv
// rtl/id_stall_controller_hazard_detect.sv - combinational required-stall count for the ID instruction
module id_stall_controller_hazard_detect
    import id_stall_controller_pkg::*;
#(
    parameter int LD_BR_STALL = 2
) (
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_use_rs1_i,
    input  logic       id_use_rs2_i,
    input  logic       id_is_branch_i,
    input  logic [4:0] id_ex_rd_i,
    input  logic       id_ex_regwrite_i,
    input  logic       id_ex_memread_i,
    input  logic [4:0] ex_mem_rd_i,
    input  logic       ex_mem_regwrite_i,
    input  logic       ex_mem_memread_i,
    output logic [1:0] n_o
);
    localparam logic [1:0] LD_BR_N = 2'(LD_BR_STALL);

    logic match_ex;
    logic match_mem;

    assign match_ex  = reg_match(id_ex_rd_i, id_ex_regwrite_i, id_rs1_i, id_use_rs1_i)
                     | reg_match(id_ex_rd_i, id_ex_regwrite_i, id_rs2_i, id_use_rs2_i);
    assign match_mem = reg_match(ex_mem_rd_i, ex_mem_regwrite_i, id_rs1_i, id_use_rs1_i)
                     | reg_match(ex_mem_rd_i, ex_mem_regwrite_i, id_rs2_i, id_use_rs2_i);

    // Branches compare in ID, so even ALU results from EX arrive too late;
    // non-branches only wait on a load sitting in EX.
    always_comb begin
        n_o = 2'd0;
        if (id_is_branch_i) begin
            if (match_ex && id_ex_memread_i) begin
                n_o = LD_BR_N;
            end else if (match_ex) begin
                n_o = 2'd1;
            end else if (match_mem && ex_mem_memread_i) begin
                n_o = 2'd1;
            end
        end else if (match_ex && id_ex_memread_i) begin
            n_o = 2'd1;
        end
    end

endmodule

// File: rtl/id_stall_controller.sv
// rtl/id_stall_controller.sv - ID-stage stall/freeze/flush sequencer with saturating event counters
module id_stall_controller
    import id_stall_controller_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int LD_BR_STALL = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    id_stall_controller_if.slave pipe_if,
    output logic [CNT_W-1:0]     stall_cycles_o,
    output logic [CNT_W-1:0]     freeze_cycles_o,
    output logic [CNT_W-1:0]     flush_count_o
);
    state_e     state_q, state_d;
    state_e     res_q, res_d;
    logic [1:0] rem_q, rem_d;
    logic [1:0] n;
    logic       stall;
    logic       freeze;
    logic       flush;

    logic [CNT_W-1:0] stall_cnt_q, freeze_cnt_q, flush_cnt_q;

    id_stall_controller_hazard_detect #(
        .LD_BR_STALL(LD_BR_STALL)
    ) u_hazard_detect (
        .id_rs1_i         (pipe_if.id_rs1),
        .id_rs2_i         (pipe_if.id_rs2),
        .id_use_rs1_i     (pipe_if.id_use_rs1),
        .id_use_rs2_i     (pipe_if.id_use_rs2),
        .id_is_branch_i   (pipe_if.id_is_branch),
        .id_ex_rd_i       (pipe_if.id_ex_rd),
        .id_ex_regwrite_i (pipe_if.id_ex_regwrite),
        .id_ex_memread_i  (pipe_if.id_ex_memread),
        .ex_mem_rd_i      (pipe_if.ex_mem_rd),
        .ex_mem_regwrite_i(pipe_if.ex_mem_regwrite),
        .ex_mem_memread_i (pipe_if.ex_mem_memread),
        .n_o              (n)
    );

    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        rem_d   = rem_q;
        stall   = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (pipe_if.dmem_busy) begin
                    state_d = ST_WAIT;
                    res_d   = ST_RUN;
                end else if (n != 2'd0) begin
                    stall = 1'b1;
                    if (n > 2'd1) begin
                        state_d = ST_HAZ;
                        rem_d   = n - 2'd1;
                    end
                end else if (pipe_if.id_is_branch && pipe_if.branch_taken) begin
                    flush = 1'b1;
                end
            end
            ST_HAZ: begin
                if (pipe_if.dmem_busy) begin
                    state_d = ST_WAIT;
                    res_d   = ST_HAZ;
                end else begin
                    stall = 1'b1;
                    if (rem_q == 2'd1) begin
                        state_d = ST_RUN;
                        rem_d   = 2'd0;
                    end else begin
                        rem_d = rem_q - 2'd1;
                    end
                end
            end
            ST_WAIT: begin
                // The drain cycle stays frozen; the resumed state acts next cycle.
                if (!pipe_if.dmem_busy) begin
                    state_d = res_q;
                end
            end
            default: begin
                state_d = ST_RUN;
                rem_d   = 2'd0;
                res_d   = ST_RUN;
            end
        endcase
    end

    assign freeze = pipe_if.dmem_busy | (state_q == ST_WAIT);

    assign pipe_if.pc_write     = !stall && !freeze;
    assign pipe_if.if_id_write  = !stall && !freeze;
    assign pipe_if.id_ex_bubble = stall;
    assign pipe_if.if_id_flush  = flush;
    assign pipe_if.pipe_freeze  = freeze;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            res_q        <= ST_RUN;
            rem_q        <= 2'd0;
            stall_cnt_q  <= '0;
            freeze_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            res_q        <= res_d;
            rem_q        <= rem_d;
            stall_cnt_q  <= sat_inc(stall_cnt_q, stall);
            freeze_cnt_q <= sat_inc(freeze_cnt_q, freeze);
            flush_cnt_q  <= sat_inc(flush_cnt_q, flush);
        end
    end

    assign stall_cycles_o  = stall_cnt_q;
    assign freeze_cycles_o = freeze_cnt_q;
    assign flush_count_o   = flush_cnt_q;

endmodule
